// File: rtl/sound_pkg.sv
// Shared constants and types for the sound path: mix weights, midpoint and
// the sample type used by the mixer, the DC blocker and the modulator.
package sound_pkg;
  localparam int MIX_W    = 10;
  localparam int W_TIMER  = 64;
  localparam int W_BEEPER = 64;
  localparam int W_TAPE   = 32;
  localparam int MIX_MID  = 512;

  typedef logic [MIX_W-1:0] mix_t;
endpackage

// File: rtl/soundmix_dcblock.sv
// First-order DC blocker. A leaky integrator of the sample difference keeps
// 8 fractional bits, and the output is re-centred on MIX_MID and clamped to the
// unsigned sample range. It is used only when SOUNDMIX_DCBLOCK_EN is defined.
module soundmix_dcblock
  import sound_pkg::*;
#(
  parameter int MIX_W = sound_pkg::MIX_W,
  parameter int DC_K  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [MIX_W-1:0] i_x,
  input  logic             i_vld,
  output logic [MIX_W-1:0] o_y,
  output logic             o_vld
);
  localparam int ACC_W = 20;
  localparam logic signed [ACC_W-1:0] MID_S = ACC_W'(MIX_MID);

  // Clamp a signed value into [0, 2^MIX_W-1].
  function automatic logic [MIX_W-1:0] sat_u(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1])
      return '0;
    else if (v[ACC_W-2:MIX_W] != '0)
      return '1;
    else
      return v[MIX_W-1:0];
  endfunction

  logic [MIX_W-1:0]        r_xprev;
  logic signed [ACC_W-1:0] r_yacc;
  logic [MIX_W-1:0]        r_y;
  logic                    r_vld;

  logic signed [MIX_W:0]   w_diff;
  logic signed [ACC_W-1:0] w_diff_ext;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] w_centred;

  assign w_diff     = $signed({1'b0, i_x}) - $signed({1'b0, r_xprev});
  assign w_diff_ext = {{(ACC_W-MIX_W-1){w_diff[MIX_W]}}, w_diff};
  assign w_acc_nxt  = r_yacc + (w_diff_ext <<< 8) - (r_yacc >>> DC_K);
  assign w_centred  = (w_acc_nxt >>> 8) + MID_S;

  // Integrate on each new sample and register the re-centred, clamped output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_xprev <= '0;
      r_yacc  <= '0;
      r_y     <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_xprev <= i_x;
        r_yacc  <= w_acc_nxt;
        r_y     <= sat_u(w_centred);
      end
    end
  end

  assign o_y   = r_y;
  assign o_vld = r_vld;
endmodule

// File: rtl/soundmix_dsm.sv
// Sound back end: weighted mix of AY level, 8253 timer outputs, beeper and
// tape-in into one unsigned sample per ce, then a first-order sigma-delta
// modulator that produces a 1-bit stream on every clock.
// Optional feature: define SOUNDMIX_DCBLOCK_EN to insert the DC blocker
// (latency 2, silence sits at mid-scale). Without it, latency is 1 and the
// sample is the raw mix.
module soundmix_dsm
  import sound_pkg::*;
#(
  parameter int MIX_W = sound_pkg::MIX_W,
  parameter int DC_K  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [7:0]       ay_sound,
  input  logic [2:0]       timer_out,
  input  logic             beeper,
  input  logic             tape_in,
  input  logic             mute,
  output logic [MIX_W-1:0] mix_out,
  output logic             mix_valid,
  output logic             dsm_out
);
  logic [1:0]       w_pop;
  logic [MIX_W-1:0] w_x;
  logic [MIX_W:0]   w_sum;
  logic [MIX_W-1:0] r_acc;
  logic             r_dsm;

  assign w_pop = 2'(timer_out[0]) + 2'(timer_out[1]) + 2'(timer_out[2]);
  assign w_x   = mute ? '0 :
                 MIX_W'(ay_sound)
               + MIX_W'(W_TIMER) * MIX_W'(w_pop)
               + MIX_W'(W_BEEPER) * MIX_W'(beeper)
               + MIX_W'(W_TAPE) * MIX_W'(tape_in);

`ifdef SOUNDMIX_DCBLOCK_EN
  logic [MIX_W-1:0] r_x;
  logic             r_xvld;
  logic [MIX_W-1:0] w_y;
  logic             w_yvld;

  // Capture the raw mix; the DC blocker consumes it on the following clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x    <= '0;
      r_xvld <= 1'b0;
    end else begin
      r_xvld <= ce;
      if (ce)
        r_x <= w_x;
    end
  end

  soundmix_dcblock #(
    .MIX_W (MIX_W),
    .DC_K  (DC_K)
  ) u_dcblock (
    .clk     (clk),
    .reset_n (reset_n),
    .i_x     (r_x),
    .i_vld   (r_xvld),
    .o_y     (w_y),
    .o_vld   (w_yvld)
  );

  assign mix_out   = w_y;
  assign mix_valid = w_yvld;
`else
  logic [MIX_W-1:0] r_mix;
  logic             r_vld;
  logic             w_unused_dck;

  // DC_K only matters when the blocker is built in.
  assign w_unused_dck = (DC_K != 0);

  // Register the raw mix on each ce; valid pulses for one clock per ce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mix <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= ce;
      if (ce)
        r_mix <= w_x;
    end
  end

  assign mix_out   = r_mix;
  assign mix_valid = r_vld;
`endif

  // The carry out of the wrap-around accumulator is the output bit, so the
  // ones density is exactly mix_out / 2^MIX_W.
  assign w_sum = {1'b0, r_acc} + {1'b0, mix_out};

  // Modulator runs every clock, independent of ce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_dsm <= 1'b0;
    end else begin
      r_acc <= w_sum[MIX_W-1:0];
      r_dsm <= w_sum[MIX_W];
    end
  end

  assign dsm_out = r_dsm;
endmodule

// File: tb/tb_soundmix_dsm.sv
// Directed bench for soundmix_dsm. The default build covers the raw mixer and
// the modulator; with SOUNDMIX_DCBLOCK_EN defined it covers the DC blocker.
module tb_soundmix_dsm;
  localparam int MIX_W = 10;
  localparam int DC_K  = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             ce;
  logic [7:0]       ay_sound;
  logic [2:0]       timer_out;
  logic             beeper;
  logic             tape_in;
  logic             mute;
  logic [MIX_W-1:0] mix_out;
  logic             mix_valid;
  logic             dsm_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soundmix_dsm #(.MIX_W(MIX_W), .DC_K(DC_K)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .ay_sound  (ay_sound),
    .timer_out (timer_out),
    .beeper    (beeper),
    .tape_in   (tape_in),
    .mute      (mute),
    .mix_out   (mix_out),
    .mix_valid (mix_valid),
    .dsm_out   (dsm_out)
  );

  typedef struct {
    logic [7:0] ay;
    logic [2:0] tm;
    logic       bp;
    logic       tp;
    logic       mu;
    int         exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] a, input logic [2:0] t,
                        input logic b, input logic tp, input logic m);
    ay_sound  = a;
    timer_out = t;
    beeper    = b;
    tape_in   = tp;
    mute      = m;
  endtask

  initial begin
    int ones;
    int viol;
    int prev;

    vecs[0] = '{8'd255, 3'b111, 1'b1, 1'b1, 1'b0, 543};
    vecs[1] = '{8'd0,   3'b000, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{8'd100, 3'b001, 1'b0, 1'b0, 1'b0, 164};
    vecs[3] = '{8'd0,   3'b110, 1'b0, 1'b0, 1'b0, 128};
    vecs[4] = '{8'd10,  3'b000, 1'b1, 1'b0, 1'b0, 74};
    vecs[5] = '{8'd0,   3'b000, 1'b0, 1'b1, 1'b0, 32};
    vecs[6] = '{8'd200, 3'b111, 1'b1, 1'b1, 1'b1, 0};
    vecs[7] = '{8'd1,   3'b101, 1'b1, 1'b1, 1'b0, 225};

    // Reset held with random activity on the inputs.
    reset_n = 1'b0;
    ce      = 1'b0;
    set_in(8'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_in(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      ce = 1'($urandom);
      tick();
    end
    check("rst_mix",   mix_out,   0);
    check("rst_valid", mix_valid, 0);
    check("rst_dsm",   dsm_out,   0);

    // Release with no ce: everything stays idle.
    ce = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("idle_mix",   mix_out,   0);
    check("idle_valid", mix_valid, 0);
    check("idle_dsm",   dsm_out,   0);

`ifndef SOUNDMIX_DCBLOCK_EN
    // Single-ce vectors: latency 1, one-clock valid, value holds afterwards.
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].ay, vecs[i].tm, vecs[i].bp, vecs[i].tp, vecs[i].mu);
      ce = 1'b1;
      tick();
      ce = 1'b0;
      check($sformatf("vec%0d_mix", i), mix_out, vecs[i].exp);
      check($sformatf("vec%0d_vld", i), mix_valid, 1);
      set_in(8'd77, 3'b010, 1'b1, 1'b0, 1'b0);
      tick();
      check($sformatf("vec%0d_hold", i), mix_out, vecs[i].exp);
      check($sformatf("vec%0d_vld_lo", i), mix_valid, 0);
    end

    // Modulator density at 256/1024.
    set_in(8'd192, 3'b001, 1'b0, 1'b0, 1'b0);
    ce = 1'b1;
    tick();
    ce = 1'b0;
    check("dens256_mix", mix_out, 256);
    tick();
    tick();
    ones = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      ones += int'(dsm_out);
    end
    check("dens256_ones", ones, 256);

    // Density at zero.
    set_in(8'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    ce = 1'b1;
    tick();
    ce = 1'b0;
    tick();
    tick();
    ones = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      ones += int'(dsm_out);
    end
    check("dens0_ones", ones, 0);

    // Mute with ce every clock, then unmute.
    set_in(8'd200, 3'b000, 1'b0, 1'b0, 1'b1);
    ce = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("mute%0d_mix", i), mix_out, 0);
      check($sformatf("mute%0d_dsm", i), dsm_out, 0);
    end
    mute = 1'b0;
    tick();
    ce = 1'b0;
    check("unmute_mix", mix_out, 200);
    check("unmute_vld", mix_valid, 1);
    tick();
`else
    // DC step up with ce every clock: saturates high, decays to mid-scale.
    set_in(8'd255, 3'b111, 1'b1, 1'b1, 1'b0);
    ce = 1'b1;
    tick();
    check("dc_lat_vld_lo", mix_valid, 0);
    tick();
    check("dc_up_first", mix_out, 1023);
    check("dc_up_vld", mix_valid, 1);
    prev = int'(mix_out);
    viol = 0;
    for (int i = 0; i < 8 * (1 << DC_K); i++) begin
      tick();
      if (int'(mix_out) > prev) viol++;
      prev = int'(mix_out);
    end
    check("dc_up_monotonic_violations", viol, 0);
    check("dc_up_settled", (prev >= 511 && prev <= 513) ? 1 : 0, 1);

    // Step down to silence: saturates low, recovers to mid-scale.
    set_in(8'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("dc_down_first", mix_out, 0);
    prev = int'(mix_out);
    viol = 0;
    for (int i = 0; i < 8 * (1 << DC_K); i++) begin
      tick();
      if (int'(mix_out) < prev) viol++;
      prev = int'(mix_out);
    end
    check("dc_down_monotonic_violations", viol, 0);
    check("dc_down_settled", (prev >= 511 && prev <= 513) ? 1 : 0, 1);
    ce = 1'b0;
    tick();
    tick();
`endif

    // Mid-stream reset with ce toggling at a 400 mix.
    set_in(8'd208, 3'b011, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ce = 1'(i % 2 == 0);
      tick();
    end
`ifndef SOUNDMIX_DCBLOCK_EN
    check("pre_rst_mix", mix_out, 400);
`endif
    ce = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_mix",   mix_out,   0);
    check("async_rst_valid", mix_valid, 0);
    check("async_rst_dsm",   dsm_out,   0);
    tick();
    ce = 1'b0;
    reset_n = 1'b1;
    tick();

    // First ce after release: no stale state from before the reset.
    set_in(8'd10, 3'b000, 1'b0, 1'b0, 1'b0);
    ce = 1'b1;
    tick();
    ce = 1'b0;
`ifdef SOUNDMIX_DCBLOCK_EN
    tick();
    check("post_rst_mix", mix_out, 522);
`else
    check("post_rst_mix", mix_out, 10);
`endif
    check("post_rst_vld", mix_valid, 1);
    tick();
    check("post_rst_vld_lo", mix_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/soundmix_dsm.md
# soundmix_dsm

Audio back end for the sound path. Takes the 8-bit AY-3-8910/YM2149 level, the three 8253 timer outputs, the beeper bit and the tape-in bit, and weights and sums them into one 10-bit sample on each `ce` strobe. It optionally DC-blocks the sample. A first-order sigma-delta modulator turns the sample into a 1-bit stream that drives the board's RC-filtered audio pin.

## Interface
- `MIX_W`, 10: sample width, unsigned.
- `DC_K`, 8: DC-blocker leak shift (pole = 1 − 2^−DC_K); unused without the macro.
- `clk` in 1: system clock; the same clock the AY wrapper runs on.
- `reset_n` in 1: asynchronous, active-low reset.
- `ce` in 1: sample strobe. Inputs are sampled only on clock edges where `ce`=1.
- `ay_sound` in 8: AY output level, unsigned.
- `timer_out` in 3: 8253 channel outputs 0..2.
- `beeper` in 1: speaker port bit.
- `tape_in` in 1: tape input monitor bit.
- `mute` in 1: forces the mix to 0.
- `mix_out` out MIX_W: current sample, unsigned, registered.
- `mix_valid` out 1: one-clock pulse when `mix_out` updates.
- `dsm_out` out 1: sigma-delta bitstream, registered, updated every `clk`.

## Operation
- Mix, computed on `ce` edges: x = ay_sound + 64·popcount(timer_out) + 64·beeper + 32·tape_in.
  - Maximum x = 255+192+64+32 = 543. It never overflows MIX_W.
  - With `mute`=1, x = 0.
- Without DC blocker: `mix_out` <= x.
- With DC blocker, on each new x:
  - y_acc (signed 20 b) <= y_acc + ((x − x_prev) <<< 8) − (y_acc >>> DC_K), where `>>>` is an arithmetic shift.
  - x_prev <= x.
  - `mix_out` = (y_acc >>> 8) + 512, saturated to [0, 1023].
- Modulator, every `clk` regardless of `ce`:
  - acc (MIX_W+1 b) <= acc[MIX_W−1:0] + mix_out.
  - `dsm_out` <= the carry (acc[MIX_W]) of that sum.
  - Long-run ones density is exactly mix_out/2^MIX_W. mix_out=0 gives a constant 0.
- `ce` low: all registers except the modulator hold.
- `ce` high continuously: one sample is processed per clock.
- Reset (asynchronous, any time, including mid-sample):
  - `mix_out`=0, `mix_valid`=0, `dsm_out`=0.
  - acc, x_prev and y_acc are cleared to 0.
  - Processing restarts cleanly on the first `ce` after release.

## Timing
- Without macro: inputs sampled at edge E (`ce`=1). `mix_out` and `mix_valid`=1 are visible after E, so latency is 1 clock.
- With macro: x is registered at E and y_acc updates at E+1. `mix_out`/`mix_valid` are visible after E+1, so latency is 2 clocks.
- `mix_valid` is high for exactly one clock per accepted `ce`. Back-to-back `ce` gives back-to-back pulses.
- `dsm_out` first reflects a new `mix_out` one clock after it changes.
- Inputs are synchronous to `clk`; no synchronisers inside. `tape_in` is synchronised upstream.

## Configuration
- Macro: `SOUNDMIX_DCBLOCK_EN`.
- Defined: the DC-blocker stage is present, latency is 2, and silence settles to `mix_out`=512.
- Undefined: there is no y_acc/x_prev logic, latency is 1, and `mix_out` equals the raw mix. Silence is 0.
- `DC_K` is accepted but ignored when the macro is undefined.

## Structure
- Shared package `sound_pkg`:
  - `MIX_W` default.
  - Weights `W_TIMER`=64, `W_BEEPER`=64, `W_TAPE`=32.
  - `MIX_MID`=512.
  - Sample typedef `mix_t` (logic [MIX_W−1:0]).
- One sub-module, `soundmix_dcblock` (x in, y out, valid in/out), instantiated only under the macro.
- The mixer and the modulator stay in the top.

## Test plan
- Reset: hold `reset_n`=0 with random inputs → `mix_out`=0, `mix_valid`=0, `dsm_out`=0. Release with no `ce` → the outputs stay 0.
- Full-scale mix, macro off: ay=255, timer=3'b111, beeper=1, tape=1, one `ce` pulse → `mix_out`=543 and a single `mix_valid` pulse one clock later.
- Modulator density: force `mix_out`=256 steady → exactly 256 ones in any aligned 1024-clock window. Repeat with `mix_out`=0 → 0 ones.
- Mute: ay=200, `mute`=1, `ce` every clock → `mix_out`=0 and `dsm_out` constant 0. Drop `mute` → `mix_out`=200 on the next valid.
- DC blocker, macro on, `ce` every clock: step x 0→543 → the first valid `mix_out`=1023 (saturated), then a monotonic decay to 512±1 within 8·2^DC_K samples. Then step to 0 → the first value is 0 (saturated low), recovering to 512.
- Reset mid-stream: assert `reset_n` low for one clock while `ce` toggles and `mix_out`=400 → all outputs are 0 immediately (async). After release, the first `ce` yields the correct mix with no stale x_prev contribution.
